// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, ALU op classes,
// opcodes, ALU control codes and datapath mux select codes.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC   = 2'b00;
    localparam logic [1:0] SRCA_RS1  = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_ZERO = 2'b11;

    // States whose exit back to FETCH completes an instruction
    function automatic logic is_retire_state(input state_t s);
        return (s == MEMWB) || (s == MEMWRITE) || (s == ALUWB) || (s == BEQ);
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
interface multicycle_controller_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      instr;
    logic             zero;
    logic             pc_write;
    logic             ir_write;
    logic             reg_write;
    logic             mem_write;
    logic             instruction_or_data;
    logic [1:0]       result_src;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_control;
    logic             illegal;
    logic [CNT_W-1:0] retired;
    logic [3:0]       state_dbg;

    modport master (
        input  instr, zero,
        output pc_write, ir_write, reg_write, mem_write, instruction_or_data,
               result_src, alu_src_a, alu_src_b, alu_control, illegal, retired, state_dbg
    );

    modport slave (
        output instr, zero,
        input  pc_write, ir_write, reg_write, mem_write, instruction_or_data,
               result_src, alu_src_a, alu_src_b, alu_control, illegal, retired, state_dbg
    );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps the FSM's ALU op class plus funct fields to the datapath ALU control code.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [6:0] opcode,
    output logic [2:0] alu_control
);

    // funct7b5 only selects subtract for R-type; on I-type it is immediate bits
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I core, with a sticky illegal-opcode flag
// and a retired-instruction counter.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input logic                    clk,
    input logic                    reset,
    multicycle_controller_if.master bus
);

    state_t           state;
    state_t           next_state;
    alu_op_t          alu_op;
    logic             pc_update;
    logic             branch;
    logic             ir_write_raw;
    logic             reg_write_raw;
    logic             mem_write_raw;
    logic             iord;
    logic [1:0]       result_src;
    logic [1:0]       src_a;
    logic [1:0]       src_b;
    logic [2:0]       alu_control;
    logic [CNT_W-1:0] retired_q;
    logic             illegal_q;
    logic [6:0]       opcode;

    assign opcode = bus.instr[6:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state    = FETCH;
        pc_update     = 1'b0;
        branch        = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        iord          = 1'b0;
        result_src    = RES_ALUOUT;
        src_a         = SRCA_PC;
        src_b         = SRCB_RS2;
        alu_op        = ALUOP_ADD;
        case (state)
            FETCH: begin
                ir_write_raw = 1'b1;
                pc_update    = 1'b1;
                src_b        = SRCB_FOUR;
                result_src   = RES_ALURESULT;
                next_state   = DECODE;
            end
            DECODE: begin
                src_b = SRCB_IMM;
                case (opcode)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_R:         next_state = EXECUTER;
                    OP_I:         next_state = EXECUTEI;
                    OP_JAL:       next_state = JAL;
                    OP_BEQ:       next_state = BEQ;
                    default:      next_state = FETCH;
                endcase
            end
            MEMADR: begin
                src_a      = SRCA_RS1;
                src_b      = SRCB_IMM;
                next_state = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                iord       = 1'b1;
                next_state = MEMWB;
            end
            MEMWB: begin
                result_src    = RES_DATA;
                reg_write_raw = 1'b1;
            end
            MEMWRITE: begin
                iord          = 1'b1;
                mem_write_raw = 1'b1;
            end
            EXECUTER: begin
                src_a      = SRCA_RS1;
                alu_op     = ALUOP_FUNCT;
                next_state = ALUWB;
            end
            EXECUTEI: begin
                src_a      = SRCA_RS1;
                src_b      = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                next_state = ALUWB;
            end
            JAL: begin
                src_b      = SRCB_FOUR;
                pc_update  = 1'b1;
                next_state = ALUWB;
            end
            ALUWB: begin
                reg_write_raw = 1'b1;
            end
            BEQ: begin
                src_a  = SRCA_RS1;
                alu_op = ALUOP_SUB;
                branch = 1'b1;
            end
            default: next_state = FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (bus.instr[14:12]),
        .funct7b5    (bus.instr[30]),
        .opcode      (opcode),
        .alu_control (alu_control)
    );

    // An illegal DECODE->FETCH exit sets the flag but is never counted as retired
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (is_retire_state(state))
                retired_q <= retired_q + CNT_W'(1);
            if (state == DECODE && next_state == FETCH)
                illegal_q <= 1'b1;
        end
    end

    // Write enables are held low for the whole reset pulse, even though state reads FETCH
    assign bus.pc_write            = (pc_update | (branch & bus.zero)) & ~reset;
    assign bus.ir_write            = ir_write_raw & ~reset;
    assign bus.reg_write           = reg_write_raw & ~reset;
    assign bus.mem_write           = mem_write_raw & ~reset;
    assign bus.instruction_or_data = iord;
    assign bus.result_src          = result_src;
    assign bus.alu_src_a           = src_a;
    assign bus.alu_src_b           = src_b;
    assign bus.alu_control         = alu_control;
    assign bus.illegal             = illegal_q;
    assign bus.retired             = retired_q;
    assign bus.state_dbg           = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle control traces are compared
// against a table-driven instruction model, with random instruction streams.
module tb_multicycle_controller;

    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   failures = 0;

    multicycle_controller_if #(.CNT_W(CNT_W)) bus ();

    multicycle_controller #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    // Model state: expected per-cycle trace of the current instruction plus counters
    logic [17:0] exp_tr[8];
    logic [17:0] obs_tr[8];
    int          exp_len;
    bit          exp_legal;
    int          model_retired = 0;
    bit          model_illegal = 0;

    function automatic logic [17:0] mk(input int st, input int pcw, input int irw, input int rw,
                                       input int mw, input int iod, input int rs, input int a,
                                       input int b, input int ac);
        return {4'(st), 1'(pcw), 1'(irw), 1'(rw), 1'(mw), 1'(iod), 2'(rs), 2'(a), 2'(b), 3'(ac)};
    endfunction

    function automatic void add_step(input logic [17:0] v);
        exp_tr[exp_len] = v;
        exp_len++;
    endfunction

    function automatic void build_expected(input logic [31:0] ins, input bit z);
        logic [6:0] op;
        int         fa;
        op = ins[6:0];
        case (ins[14:12])
            3'd0:    fa = (op == 7'b0110011 && ins[30]) ? 1 : 0;
            3'd2:    fa = 5;
            3'd6:    fa = 3;
            3'd7:    fa = 2;
            default: fa = 0;
        endcase
        exp_len   = 0;
        exp_legal = 1'b1;
        add_step(mk(0, 1, 1, 0, 0, 0, 2, 0, 1, 0));
        add_step(mk(1, 0, 0, 0, 0, 0, 0, 0, 2, 0));
        case (op)
            7'b0000011: begin
                add_step(mk(2, 0, 0, 0, 0, 0, 0, 1, 2, 0));
                add_step(mk(3, 0, 0, 0, 0, 1, 0, 0, 0, 0));
                add_step(mk(4, 0, 0, 1, 0, 0, 1, 0, 0, 0));
            end
            7'b0100011: begin
                add_step(mk(2, 0, 0, 0, 0, 0, 0, 1, 2, 0));
                add_step(mk(5, 0, 0, 0, 1, 1, 0, 0, 0, 0));
            end
            7'b0110011: begin
                add_step(mk(6, 0, 0, 0, 0, 0, 0, 1, 0, fa));
                add_step(mk(8, 0, 0, 1, 0, 0, 0, 0, 0, 0));
            end
            7'b0010011: begin
                add_step(mk(7, 0, 0, 0, 0, 0, 0, 1, 2, fa));
                add_step(mk(8, 0, 0, 1, 0, 0, 0, 0, 0, 0));
            end
            7'b1101111: begin
                add_step(mk(9, 1, 0, 0, 0, 0, 0, 0, 1, 0));
                add_step(mk(8, 0, 0, 1, 0, 0, 0, 0, 0, 0));
            end
            7'b1100011: add_step(mk(10, int'(z), 0, 0, 0, 0, 0, 1, 0, 1));
            default:    exp_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr(input int cls);
        logic [31:0] ins;
        logic [6:0]  op;
        ins = $urandom;
        case (cls)
            0: op = 7'b0000011;
            1: op = 7'b0100011;
            2: op = 7'b0110011;
            3: op = 7'b0010011;
            4: op = 7'b1101111;
            5: op = 7'b1100011;
            default: begin
                op = 7'b1111111;
                for (int k = 0; k < 50; k++) begin
                    op = 7'($urandom);
                    if (!(op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                     7'b1101111, 7'b1100011}))
                        break;
                    op = 7'b1111111;
                end
            end
        endcase
        ins[6:0] = op;
        return ins;
    endfunction

    // Drives one instruction from FETCH and records one observation per model cycle
    task automatic run_instr(input logic [31:0] ins, input bit z);
        build_expected(ins, z);
        for (int c = 0; c < exp_len; c++) begin
            bus.instr = ins;
            bus.zero  = z;
            #1;
            obs_tr[c] = {bus.state_dbg, bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write,
                         bus.instruction_or_data, bus.result_src, bus.alu_src_a, bus.alu_src_b,
                         bus.alu_control};
            @(posedge clk);
            #1;
        end
        if (exp_legal) model_retired = (model_retired + 1) % (1 << CNT_W);
        else           model_illegal = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_retired = 0;
        model_illegal = 1'b0;
    endtask

    task automatic test_reset();
        bus.instr = 32'h0;
        bus.zero  = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        tests++;
        if ({bus.state_dbg, bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write} !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_hold: state/pc/ir/reg/mem = %h, want 00", 
                     {bus.state_dbg, bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write});
        end
        tests++;
        if ({bus.instruction_or_data, bus.result_src, bus.alu_src_a, bus.alu_src_b} !== 7'b0100001) begin
            failures++;
            $display("[TB] FAIL reset_muxes: got %b, want 0100001",
                     {bus.instruction_or_data, bus.result_src, bus.alu_src_a, bus.alu_src_b});
        end
        reset = 1'b0;
        #1;
        tests++;
        if ({bus.state_dbg, bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write} !== 8'b0000_1100) begin
            failures++;
            $display("[TB] FAIL reset_release: state/ir/pc/reg/mem = %b, want 00001100",
                     {bus.state_dbg, bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write});
        end
        tests++;
        if (bus.retired !== '0 || bus.illegal !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_counters: retired=%0d illegal=%b, want 0 0", bus.retired, bus.illegal);
        end
    endtask

    task automatic test_lw();
        run_instr(32'h00002083, 1'b0);
        for (int c = 0; c < exp_len; c++) begin
            tests++;
            if (obs_tr[c] !== exp_tr[c]) begin
                failures++;
                $display("[TB] FAIL lw_cycle%0d: got %h, want %h", c, obs_tr[c], exp_tr[c]);
            end
        end
        tests++;
        if (bus.retired !== CNT_W'(1)) begin
            failures++;
            $display("[TB] FAIL lw_retired: got %0d, want 1", bus.retired);
        end
    endtask

    task automatic test_alu();
        logic [31:0] prog[2];
        prog[0] = 32'h40208033;
        prog[1] = 32'h0020F033;
        for (int i = 0; i < 2; i++) begin
            run_instr(prog[i], 1'($urandom));
            for (int c = 0; c < exp_len; c++) begin
                tests++;
                if (obs_tr[c] !== exp_tr[c]) begin
                    failures++;
                    $display("[TB] FAIL alu%0d_cycle%0d: got %h, want %h", i, c, obs_tr[c], exp_tr[c]);
                end
            end
            tests++;
            if (obs_tr[2][2:0] !== (i == 0 ? 3'b001 : 3'b010)) begin
                failures++;
                $display("[TB] FAIL alu%0d_control: got %b", i, obs_tr[2][2:0]);
            end
        end
        tests++;
        if (bus.retired !== CNT_W'(3)) begin
            failures++;
            $display("[TB] FAIL alu_retired: got %0d, want 3", bus.retired);
        end
    endtask

    task automatic test_beq();
        for (int i = 0; i < 2; i++) begin
            run_instr(32'h00000063, (i == 0));
            tests++;
            if (obs_tr[2][13] !== (i == 0)) begin
                failures++;
                $display("[TB] FAIL beq_pc_write_zero%0d: got %b", (i == 0), obs_tr[2][13]);
            end
            for (int c = 0; c < exp_len; c++) begin
                tests++;
                if (obs_tr[c] !== exp_tr[c]) begin
                    failures++;
                    $display("[TB] FAIL beq%0d_cycle%0d: got %h, want %h", i, c, obs_tr[c], exp_tr[c]);
                end
            end
        end
        tests++;
        if (bus.retired !== CNT_W'(5)) begin
            failures++;
            $display("[TB] FAIL beq_retired: got %0d, want 5", bus.retired);
        end
    endtask

    task automatic test_illegal();
        for (int i = 0; i < 2; i++) begin
            run_instr(i == 0 ? 32'hFFFFFFFF : 32'h00000013, 1'b0);
            for (int c = 0; c < exp_len; c++) begin
                tests++;
                if (obs_tr[c] !== exp_tr[c]) begin
                    failures++;
                    $display("[TB] FAIL illegal%0d_cycle%0d: got %h, want %h", i, c, obs_tr[c], exp_tr[c]);
                end
            end
            tests++;
            if (bus.illegal !== 1'b1 || bus.retired !== CNT_W'(5 + i)) begin
                failures++;
                $display("[TB] FAIL illegal%0d_flags: illegal=%b retired=%0d, want 1 %0d",
                         i, bus.illegal, bus.retired, 5 + i);
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.instr = 32'h00112023;
        bus.zero  = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        tests++;
        if (bus.mem_write !== 1'b1 || bus.state_dbg !== 4'd5) begin
            failures++;
            $display("[TB] FAIL midreset_pre: mem_write=%b state=%0d, want 1 5", bus.mem_write, bus.state_dbg);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (bus.mem_write !== 1'b0 || bus.state_dbg !== 4'd0 || bus.retired !== '0 || bus.illegal !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset: mem_write=%b state=%0d retired=%0d illegal=%b, want 0 0 0 0",
                     bus.mem_write, bus.state_dbg, bus.retired, bus.illegal);
        end
        do_reset();
    endtask

    task automatic test_random();
        int cls;
        for (int n = 0; n < 40; n++) begin
            cls = $urandom_range(0, 6);
            run_instr(rand_instr(cls), 1'($urandom));
            for (int c = 0; c < exp_len; c++) begin
                tests++;
                if (obs_tr[c] !== exp_tr[c]) begin
                    failures++;
                    $display("[TB] FAIL rand%0d_cycle%0d: got %h, want %h", n, c, obs_tr[c], exp_tr[c]);
                end
            end
            tests++;
            if (bus.retired !== CNT_W'(model_retired) || bus.illegal !== model_illegal) begin
                failures++;
                $display("[TB] FAIL rand%0d_counters: retired=%0d illegal=%b, want %0d %b",
                         n, bus.retired, bus.illegal, model_retired, model_illegal);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int n = 0; n < (1 << CNT_W) - 1; n++)
            run_instr(rand_instr($urandom_range(0, 5)), 1'($urandom));
        tests++;
        if (bus.retired !== {CNT_W{1'b1}}) begin
            failures++;
            $display("[TB] FAIL wrap_allones: got %0d, want %0d", bus.retired, (1 << CNT_W) - 1);
        end
        for (int n = 0; n < 2; n++)
            run_instr(rand_instr($urandom_range(0, 5)), 1'($urandom));
        tests++;
        if (bus.retired !== CNT_W'(1) || model_retired != 1) begin
            failures++;
            $display("[TB] FAIL wrap: got %0d, want 1", bus.retired);
        end
    endtask

    initial begin
        bus.instr = 32'h0;
        bus.zero  = 1'b0;
        test_reset();
        test_lw();
        test_alu();
        test_beq();
        test_illegal();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
